// File: rtl/ssd1331_pkg.sv
// -----------------------------------------------------------------------------
// ssd1331_pkg
// Shared definitions for the SSD1331 rectangle-fill command generator:
//   - default display geometry and SSD1331 addressing opcodes
//   - position of the D/C flag inside a 16-bit stream word
//   - coordinate and pixel-counter widths
//   - fill engine state enumeration
//   - make_word(): packs a D/C flag and a byte into a stream word
// -----------------------------------------------------------------------------
package ssd1331_pkg;

    localparam int unsigned   COLS_DEFAULT    = 96;
    localparam int unsigned   ROWS_DEFAULT    = 64;
    localparam logic [7:0]    CMD_COL_DEFAULT = 8'h15;
    localparam logic [7:0]    CMD_ROW_DEFAULT = 8'h75;

    // D/C flag position in TDATA: 0 = command byte, 1 = data byte
    localparam int unsigned   DC_BIT          = 8;

    localparam int unsigned   X_W             = 7;
    localparam int unsigned   Y_W             = 6;
    // Holds up to 96*64 = 6144 pixels without wrapping
    localparam int unsigned   PIX_CNT_W       = 13;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_COL_OP = 4'd1,
        ST_COL_A  = 4'd2,
        ST_COL_B  = 4'd3,
        ST_ROW_OP = 4'd4,
        ST_ROW_A  = 4'd5,
        ST_ROW_B  = 4'd6,
        ST_PIX_HI = 4'd7,
        ST_PIX_LO = 4'd8
    } fill_state_e;

    // Build a stream word: upper bits zero, D/C flag, then the payload byte
    function automatic logic [15:0] make_word(input logic dc, input logic [7:0] data_byte);
        logic [15:0] w;
        w         = 16'h0000;
        w[DC_BIT] = dc;
        w[7:0]    = data_byte;
        return w;
    endfunction

endpackage

// File: rtl/ssd1331_fill_engine.sv
// -----------------------------------------------------------------------------
// ssd1331_fill_engine
// Turns one rectangle-fill request into the full SSD1331 SPI byte stream:
// set-column-address command + 2 args, set-row-address command + 2 args, then
// two colour bytes per pixel of the window. Output is a registered 16-bit
// valid/ready stream feeding the SPI serialiser.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_x0/x1         window columns, inclusive (7 bits)
//   req_y0/y1         window rows, inclusive (6 bits)
//   req_colour        RGB565 fill colour
//   req_error         one-cycle pulse after an invalid request is accepted
//   busy              valid request in flight until its final word handshakes
//   TDATA             [8]=D/C, [7:0]=byte, [15:9]=0
//   TVALID/TLAST      stream qualifiers; TLAST marks the last pixel byte
//   TREADY            downstream accept
// -----------------------------------------------------------------------------
module ssd1331_fill_engine
    import ssd1331_pkg::*;
#(
    parameter int unsigned COLS    = COLS_DEFAULT,
    parameter int unsigned ROWS    = ROWS_DEFAULT,
    parameter logic [7:0]  CMD_COL = CMD_COL_DEFAULT,
    parameter logic [7:0]  CMD_ROW = CMD_ROW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [X_W-1:0] req_x0,
    input  logic [X_W-1:0] req_x1,
    input  logic [Y_W-1:0] req_y0,
    input  logic [Y_W-1:0] req_y1,
    input  logic [15:0]    req_colour,
    output logic           req_error,
    output logic           busy,
    output logic [15:0]    TDATA,
    output logic           TVALID,
    output logic           TLAST,
    input  logic           TREADY
);

    // Limits widened by one bit so the "< COLS/ROWS" compare cannot alias
    localparam logic [X_W:0] COLS_LIM = (X_W + 1)'(COLS);
    localparam logic [Y_W:0] ROWS_LIM = (Y_W + 1)'(ROWS);

    fill_state_e          state_q, state_d;
    logic [X_W-1:0]       x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0]       y0_q, y0_d, y1_q, y1_d;
    logic [15:0]          colour_q, colour_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]          tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 req_ready_q, req_ready_d;
    logic                 req_error_q, req_error_d;
    logic                 busy_q, busy_d;

    logic                 accept_s;
    logic                 hs_s;
    logic                 req_ok_s;
    logic [X_W-1:0]       width_s;
    logic [Y_W:0]         height_s;
    logic [13:0]          pix_total_s;

    assign accept_s = req_valid && req_ready_q;
    assign hs_s     = tvalid_q && TREADY;

    // Request validation and pixel count, evaluated in the accept cycle
    always_comb begin
        req_ok_s    = (req_x0 <= req_x1) && ({1'b0, req_x1} < COLS_LIM) &&
                      (req_y0 <= req_y1) && ({1'b0, req_y1} < ROWS_LIM);
        // Only meaningful when req_ok_s; the window is at least one pixel
        width_s     = req_x1 - req_x0 + 7'd1;
        height_s    = {1'b0, req_y1} - {1'b0, req_y0} + 7'd1;
        pix_total_s = {7'd0, width_s} * {7'd0, height_s};
    end

    // Next-state, field capture, pixel counter and next output word
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        colour_d    = colour_q;
        pix_cnt_d   = pix_cnt_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        req_error_d = 1'b0;

        // The output register always holds the word of the current state;
        // on a handshake it is reloaded with the successor's word.
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_ok_s) begin
                        x0_d        = req_x0;
                        x1_d        = req_x1;
                        y0_d        = req_y0;
                        y1_d        = req_y1;
                        colour_d    = req_colour;
                        pix_cnt_d   = pix_total_s[PIX_CNT_W-1:0];
                        state_d     = ST_COL_OP;
                        tdata_d     = make_word(1'b0, CMD_COL);
                        tvalid_d    = 1'b1;
                        tlast_d     = 1'b0;
                        req_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end else begin
                        // Invalid window: swallow it, flag it, stay idle
                        req_error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COL_OP: begin
                if (hs_s) begin
                    state_d = ST_COL_A;
                    tdata_d = make_word(1'b0, {1'b0, x0_q});
                end else begin
                    state_d = ST_COL_OP;
                end
            end
            ST_COL_A: begin
                if (hs_s) begin
                    state_d = ST_COL_B;
                    tdata_d = make_word(1'b0, {1'b0, x1_q});
                end else begin
                    state_d = ST_COL_A;
                end
            end
            ST_COL_B: begin
                if (hs_s) begin
                    state_d = ST_ROW_OP;
                    tdata_d = make_word(1'b0, CMD_ROW);
                end else begin
                    state_d = ST_COL_B;
                end
            end
            ST_ROW_OP: begin
                if (hs_s) begin
                    state_d = ST_ROW_A;
                    tdata_d = make_word(1'b0, {2'b00, y0_q});
                end else begin
                    state_d = ST_ROW_OP;
                end
            end
            ST_ROW_A: begin
                if (hs_s) begin
                    state_d = ST_ROW_B;
                    tdata_d = make_word(1'b0, {2'b00, y1_q});
                end else begin
                    state_d = ST_ROW_A;
                end
            end
            ST_ROW_B: begin
                if (hs_s) begin
                    state_d = ST_PIX_HI;
                    tdata_d = make_word(1'b1, colour_q[15:8]);
                end else begin
                    state_d = ST_ROW_B;
                end
            end
            ST_PIX_HI: begin
                if (hs_s) begin
                    state_d = ST_PIX_LO;
                    tdata_d = make_word(1'b1, colour_q[7:0]);
                    // Counter still holds the remaining pixels including this one
                    tlast_d = (pix_cnt_q == 13'd1);
                end else begin
                    state_d = ST_PIX_HI;
                end
            end
            ST_PIX_LO: begin
                if (hs_s) begin
                    pix_cnt_d = pix_cnt_q - 13'd1;
                    if (pix_cnt_q > 13'd1) begin
                        state_d = ST_PIX_HI;
                        tdata_d = make_word(1'b1, colour_q[15:8]);
                        tlast_d = 1'b0;
                    end else begin
                        // Final word taken: go idle and reopen the request port
                        state_d     = ST_IDLE;
                        tdata_d     = 16'h0000;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end else begin
                    state_d = ST_PIX_LO;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tdata_d     = 16'h0000;
                tvalid_d    = 1'b0;
                tlast_d     = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                pix_cnt_d   = 13'd0;
            end
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x0_q        <= 7'd0;
            x1_q        <= 7'd0;
            y0_q        <= 6'd0;
            y1_q        <= 6'd0;
            colour_q    <= 16'h0000;
            pix_cnt_q   <= 13'd0;
            tdata_q     <= 16'h0000;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            req_ready_q <= 1'b1;
            req_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            colour_q    <= colour_d;
            pix_cnt_q   <= pix_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            req_ready_q <= req_ready_d;
            req_error_q <= req_error_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_error = req_error_q;
    assign busy      = busy_q;
    assign TDATA     = tdata_q;
    assign TVALID    = tvalid_q;
    assign TLAST     = tlast_q;

endmodule
